serial_addsub: RTL and testbench

- Parametrised bit-serial adder/subtractor for WIDTH-bit operands.
- A single full-adder cell and a carry flip-flop process one bit per clock, LSB first.
- start/busy/done handshake; registered sum, carry-out and signed-overflow flags.
- Used where area matters more than latency; the parallel full-adder datapath stays the combinational reference.

---
 rtl/serial_addsub.sv | 122 ++++++++++++
 tb/tb_serial_addsub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. One full-adder cell and a carry flop
// process one operand bit per clock, LSB first. A start/busy/done
// handshake frames each operation; sum, carry-out and signed overflow
// are registered and held until the next completion.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-2:0]   r_res;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_bit;
  logic               w_carry;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_next;

  // Full-adder sum output.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Full-adder carry output (majority of the three inputs).
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  assign w_bit      = fa_sum(r_a[0], r_b[0], r_carry);
  assign w_carry    = fa_carry(r_a[0], r_b[0], r_carry);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  // New result bit enters at the top; after the final bit this is the
  // complete result with bit 0 at position 0.
  assign w_res_next = {w_bit, r_res};

  // Control FSM plus serial datapath: accept operands in IDLE, one bit per cycle in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1, so invert B and force the carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_res_next[WIDTH-1:1];
          r_carry <= w_carry;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // On the MSB step r_carry still holds the carry into the MSB,
            // so overflow is that carry XOR the carry out of the MSB.
            r_sum   <= w_res_next;
            r_cout  <= w_carry;
            r_ovf   <= r_carry ^ w_carry;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: three instances (WIDTH 8, 2, 16)
// share one set of inputs; results are compared against hand-computed
// constants and a word-level arithmetic model.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy2, done2, cout2, ovf2;
  logic [1:0]  sum2;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .a(a[1:0]), .b(b[1:0]), .cin(cin),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .a(a[15:0]), .b(b[15:0]), .cin(cin),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word-level reference: returns {ovf, cout, sum[63:0]} for a given width.
  function automatic logic [65:0] model(input int w, input logic [63:0] ta,
                                        input logic [63:0] tb_, input logic tsub,
                                        input logic tcin);
    logic [64:0] m, mh, bb, full, part;
    logic        c, co, cm;
    m    = (65'd1 << w) - 65'd1;
    mh   = (65'd1 << (w - 1)) - 65'd1;
    bb   = {1'b0, (tsub ? ~tb_ : tb_)};
    c    = tsub ? 1'b1 : tcin;
    full = ({1'b0, ta} & m) + (bb & m) + 65'(c);
    part = ({1'b0, ta} & mh) + (bb & mh) + 65'(c);
    co   = full[w];
    cm   = part[w-1];
    return {cm ^ co, co, full[63:0] & m[63:0]};
  endfunction

  // Run one operation on all three instances; optionally pulse start again
  // with junk operands at cycle inj after accept (0 = no extra pulse).
  task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_,
                       input logic tsub, input logic tcin, input int inj,
                       output logic [7:0] s8, output logic c8, output logic o8);
    logic [65:0] e8, e2, e16;
    logic [1:0]  s2;
    logic [15:0] s16;
    logic        c2, o2, c16, o16;
    int          lat8, lat2, lat16, nd8, nb8;
    e8  = model(8, ta, tb_, tsub, tcin);
    e2  = model(2, ta, tb_, tsub, tcin);
    e16 = model(16, ta, tb_, tsub, tcin);
    s8 = '0; c8 = 1'b0; o8 = 1'b0;
    s2 = '0; c2 = 1'b0; o2 = 1'b0;
    s16 = '0; c16 = 1'b0; o16 = 1'b0;
    lat8 = -1; lat2 = -1; lat16 = -1; nd8 = 0;
    @(negedge clk);
    a = ta; b = tb_; sub = tsub; cin = tcin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_; sub = ~tsub; cin = ~tcin;
    nb8 = busy8 ? 1 : 0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (cyc == inj) begin
        start = 1'b1; a = 64'h0123_4567_89AB_CDEF; b = 64'h0F0F_0F0F_0F0F_0F0F;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (busy8) nb8++;
      if (done8) begin
        nd8++;
        if (lat8 < 0) begin lat8 = cyc; s8 = sum8; c8 = cout8; o8 = ovf8; end
      end
      if (done2 && lat2 < 0) begin lat2 = cyc; s2 = sum2; c2 = cout2; o2 = ovf2; end
      if (done16 && lat16 < 0) begin lat16 = cyc; s16 = sum16; c16 = cout16; o16 = ovf16; end
    end
    start = 1'b0;
    chk("lat8", 64'(lat8), 64'd8);
    chk("ndone8", 64'(nd8), 64'd1);
    chk("busy8_cycles", 64'(nb8), 64'd8);
    chk("sum8_model", 64'(s8), e8[63:0]);
    chk("cout8_model", 64'(c8), 64'(e8[64]));
    chk("ovf8_model", 64'(o8), 64'(e8[65]));
    chk("lat2", 64'(lat2), 64'd2);
    chk("sum2_model", 64'(s2), e2[63:0]);
    chk("cout2_model", 64'(c2), 64'(e2[64]));
    chk("ovf2_model", 64'(o2), 64'(e2[65]));
    chk("lat16", 64'(lat16), 64'd16);
    chk("sum16_model", 64'(s16), e16[63:0]);
    chk("cout16_model", 64'(c16), 64'(e16[64]));
    chk("ovf16_model", 64'(o16), 64'(e16[65]));
  endtask

  initial begin
    logic [7:0] s;
    logic       c, o;
    int         nd, prev, ndone;

    // Reset state
    #1;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_sum", 64'(sum8), 64'd0);
    chk("rst_cout", 64'(cout8), 64'd0);
    chk("rst_ovf", 64'(ovf8), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_done", 64'(done8), 64'd0);

    // Directed add/subtract vectors
    do_op(64'h5A, 64'h3C, 1'b0, 1'b0, 0, s, c, o);
    chk("add5A3C_sum", 64'(s), 64'h96);
    chk("add5A3C_cout", 64'(c), 64'd0);
    chk("add5A3C_ovf", 64'(o), 64'd1);

    do_op(64'hFF, 64'h01, 1'b0, 1'b1, 0, s, c, o);
    chk("addFF01c_sum", 64'(s), 64'h01);
    chk("addFF01c_cout", 64'(c), 64'd1);
    chk("addFF01c_ovf", 64'(o), 64'd0);

    do_op(64'h7F, 64'h00, 1'b0, 1'b1, 0, s, c, o);
    chk("add7F00c_sum", 64'(s), 64'h80);
    chk("add7F00c_cout", 64'(c), 64'd0);
    chk("add7F00c_ovf", 64'(o), 64'd1);

    do_op(64'h10, 64'h20, 1'b1, 1'b0, 0, s, c, o);
    chk("sub1020_sum", 64'(s), 64'hF0);
    chk("sub1020_cout", 64'(c), 64'd0);
    chk("sub1020_ovf", 64'(o), 64'd0);

    do_op(64'h80, 64'h01, 1'b1, 1'b1, 0, s, c, o);
    chk("sub8001_sum", 64'(s), 64'h7F);
    chk("sub8001_cout", 64'(c), 64'd1);
    chk("sub8001_ovf", 64'(o), 64'd1);

    // Start pulsed while busy is ignored
    do_op(64'h5A, 64'h3C, 1'b0, 1'b0, 3, s, c, o);
    chk("busy_start_sum", 64'(s), 64'h96);

    // Start held high: one result every WIDTH+1 cycles
    repeat (4) @(negedge clk);
    a = 64'h33; b = 64'h44; sub = 1'b1; cin = 1'b0; start = 1'b1;
    nd = 0; prev = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        nd++;
        chk("held_sum", 64'(sum8), 64'hEF);
        chk("held_cout", 64'(cout8), 64'd0);
        if (prev < 0) chk("held_first", 64'(cyc), 64'd8);
        else chk("held_period", 64'(cyc - prev), 64'd9);
        prev = cyc;
      end
    end
    start = 1'b0;
    chk("held_count", 64'(nd), 64'd4);
    repeat (20) @(negedge clk);

    // Asynchronous reset mid-operation
    a = 64'h33; b = 64'h44; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy8), 64'd0);
    chk("arst_done", 64'(done8), 64'd0);
    chk("arst_sum", 64'(sum8), 64'd0);
    chk("arst_cout", 64'(cout8), 64'd0);
    chk("arst_ovf", 64'(ovf8), 64'd0);
    chk("arst_sum16", 64'(sum16), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done8 || done16 || done2) ndone++;
    end
    chk("arst_no_done", 64'(ndone), 64'd0);
    do_op(64'h01, 64'h01, 1'b0, 1'b0, 0, s, c, o);
    chk("post_rst_sum", 64'(s), 64'h02);

    // Random operands across all three widths against the model
    for (int i = 0; i < 6; i++) begin
      do_op({$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, s, c, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
